// File: rtl/reg_ctrl_sequencer.sv
// reg_ctrl_sequencer: turns CLEAR / LOAD / STEP_UP / STEP_DOWN requests into
// per-cycle ctrl codes for a 3-bit-ctrl register. It also keeps a shadow copy
// of the value that register must hold.
module reg_ctrl_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int STEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_arg,
    output logic [2:0]            ctrl,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] shadow
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    typedef enum logic [1:0] {OP_CLEAR, OP_LOAD, OP_STEP_UP, OP_STEP_DOWN} op_t;
    typedef enum logic [2:0] {
        CTRL_NONE = 3'd0,
        CTRL_CLR  = 3'd1,
        CTRL_LOAD = 3'd2,
        CTRL_INCR = 3'd3,
        CTRL_DECR = 3'd4
    } ctrl_t;

    localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] STEP_ONE = STEP_WIDTH'(1);

    state_t                  state;
    op_t                     op_q;
    ctrl_t                   ctrl_q;
    ctrl_t                   first_code;
    logic [DATA_WIDTH-1:0]   arg_q;
    logic [STEP_WIDTH-1:0]   cnt;
    op_t                     req_op_e;
    logic [STEP_WIDTH-1:0]   req_k;
    logic                    req_is_step;
    logic                    last_issue;

    assign req_op_e    = op_t'(req_op);
    assign req_k       = req_arg[STEP_WIDTH-1:0];
    assign req_is_step = req_op[1];
    assign req_ready   = (state == IDLE);
    assign ctrl        = ctrl_q;
    assign last_issue  = !op_q[1] || (cnt == STEP_ONE);

    // ctrl code for the first issue cycle of an incoming request
    always_comb begin
        first_code = CTRL_NONE;
        case (req_op_e)
            OP_CLEAR:     first_code = CTRL_CLR;
            OP_LOAD:      first_code = CTRL_LOAD;
            OP_STEP_UP:   first_code = CTRL_INCR;
            OP_STEP_DOWN: first_code = CTRL_DECR;
            default:      first_code = CTRL_NONE;
        endcase
    end

    // Sequencer FSM. All outputs are registered. The shadow value updates on
    // the same edge at which the register samples the ctrl code being driven.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            op_q     <= OP_CLEAR;
            ctrl_q   <= CTRL_NONE;
            arg_q    <= '0;
            cnt      <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            shadow   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op_e;
                        arg_q <= req_arg;
                        cnt   <= req_k;
                        busy  <= 1'b1;
                        if (req_is_step && (req_k == '0)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            ctrl_q   <= first_code;
                            data_out <= (req_op_e == OP_LOAD) ? req_arg : '0;
                        end
                    end
                end
                ISSUE: begin
                    case (op_q)
                        OP_CLEAR:     shadow <= '0;
                        OP_LOAD:      shadow <= arg_q;
                        OP_STEP_UP:   shadow <= shadow + DATA_ONE;
                        OP_STEP_DOWN: shadow <= shadow - DATA_ONE;
                        default:      shadow <= shadow;
                    endcase
                    if (last_issue) begin
                        state    <= DONE;
                        ctrl_q   <= CTRL_NONE;
                        data_out <= '0;
                        done     <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt - STEP_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    ctrl_q   <= CTRL_NONE;
                    data_out <= '0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_ctrl_sequencer.sv
// Directed testbench for reg_ctrl_sequencer. It attaches a behavioural
// register to ctrl/data_out and compares shadow against it on every cycle.
module tb_reg_ctrl_sequencer;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_arg;
    logic [2:0] ctrl;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic [7:0] shadow;
    logic [7:0] regm;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    reg_ctrl_sequencer #(.DATA_WIDTH(8), .STEP_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_arg   (req_arg),
        .ctrl      (ctrl),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .shadow    (shadow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached 3-bit-ctrl register, sharing the sequencer's reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) regm <= 8'h00;
        else begin
            case (ctrl)
                3'd1:    regm <= 8'h00;
                3'd2:    regm <= data_out;
                3'd3:    regm <= regm + 8'h01;
                3'd4:    regm <= regm - 8'h01;
                default: regm <= regm;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check("shadow_vs_reg", 32'(shadow), 32'(regm));
    endtask

    task automatic run_req(input logic [1:0] op, input logic [7:0] arg,
                           input logic [2:0] code, input int unsigned n,
                           input logic [7:0] exp_shadow);
        check("ready_pre", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_arg   = arg;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            check("ctrl_issue", 32'(ctrl), 32'(code));
            check("data_issue", 32'(data_out), (code == 3'd2) ? 32'(arg) : 32'd0);
            check("busy_issue", 32'(busy), 32'd1);
            check("ready_issue", 32'(req_ready), 32'd0);
            check("done_issue", 32'(done), 32'd0);
            tick();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("ctrl_done", 32'(ctrl), 32'd0);
        check("busy_done", 32'(busy), 32'd1);
        check("ready_done", 32'(req_ready), 32'd0);
        tick();
        check("done_fall", 32'(done), 32'd0);
        check("ready_post", 32'(req_ready), 32'd1);
        check("busy_post", 32'(busy), 32'd0);
        check("shadow_final", 32'(shadow), 32'(exp_shadow));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_arg   = 8'h00;

        // Reset asserted mid-cycle takes effect immediately
        #2 rst = 1'b0;
        #1;
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_shadow", 32'(shadow), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_data", 32'(data_out), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ctrl", 32'(ctrl), 32'd0);
            check("idle_ready", 32'(req_ready), 32'd1);
        end

        // LOAD then STEP_UP k=3
        run_req(2'd1, 8'hA5, 3'd2, 1, 8'hA5);
        run_req(2'd2, 8'h03, 3'd3, 3, 8'hA8);
        check("reg_a8", 32'(regm), 32'hA8);

        // Wrap in both directions
        run_req(2'd1, 8'hFE, 3'd2, 1, 8'hFE);
        run_req(2'd2, 8'h04, 3'd3, 4, 8'h02);
        run_req(2'd3, 8'h05, 3'd4, 5, 8'hFD);
        check("reg_fd", 32'(regm), 32'hFD);

        // STEP_DOWN with k=0 (upper arg bits ignored)
        run_req(2'd3, 8'h30, 3'd4, 0, 8'hFD);

        // Handshake: valid held high with changing op/arg during STEP_UP k=15
        check("hs_ready_pre", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_arg   = 8'hFF;
        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < 15; i++) begin
            req_op  = 2'(i % 4);
            req_arg = 8'(i * 17);
            check("hs_ctrl", 32'(ctrl), 32'd3);
            check("hs_ready", 32'(req_ready), 32'd0);
            tick();
        end
        check("hs_done", 32'(done), 32'd1);
        check("hs_ready_done", 32'(req_ready), 32'd0);
        check("hs_shadow", 32'(shadow), 32'h0C);
        req_op  = 2'd1;
        req_arg = 8'h55;
        tick();
        check("hs_idle_done", 32'(done), 32'd0);
        check("hs_idle_ready", 32'(req_ready), 32'd1);
        check("hs_idle_ctrl", 32'(ctrl), 32'd0);
        tick();
        req_valid = 1'b0;
        check("hs2_ctrl", 32'(ctrl), 32'd2);
        check("hs2_data", 32'(data_out), 32'h55);
        check("hs2_ready", 32'(req_ready), 32'd0);
        tick();
        check("hs2_done", 32'(done), 32'd1);
        check("hs2_shadow", 32'(shadow), 32'h55);
        tick();
        check("hs2_ready_post", 32'(req_ready), 32'd1);

        // Reset during the 2nd issue cycle of STEP_UP k=8
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_arg   = 8'h08;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        tick();
        check("mid_ctrl", 32'(ctrl), 32'd3);
        check("mid_shadow", 32'(shadow), 32'h56);
        #2 rst = 1'b0;
        #1;
        check("abort_ctrl", 32'(ctrl), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_shadow", 32'(shadow), 32'd0);
        check("abort_reg", 32'(regm), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("abort_no_done", 32'(done), 32'd0);
        end
        rst = 1'b1;
        tick();
        check("post_rst_done", 32'(done), 32'd0);
        run_req(2'd1, 8'h3C, 3'd2, 1, 8'h3C);
        run_req(2'd0, 8'h77, 3'd1, 1, 8'h00);
        check("reg_clear", 32'(regm), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_ctrl_sequencer.md
# reg_ctrl_sequencer

Command-side driver for the 3-bit-ctrl register block: accepts high-level requests over a valid/ready handshake and emits the per-cycle ctrl code sequence (CLEAR, LOAD, repeated INCR/DECR) plus load data onto a register's ctrl/data_input ports. It keeps a shadow copy of the value the driven register must hold, so the datapath can read the expected value without a return path. It sits between the control FSM and any register instance on the datapath.

## Interface
- DATA_WIDTH, 8, width of load data and shadow value; must match the driven register
- STEP_WIDTH, 4, width of step count taken from req_arg[STEP_WIDTH-1:0]; STEP_WIDTH <= DATA_WIDTH
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept; combinational from state
- req_op  in  2  0 CLEAR, 1 LOAD, 2 STEP_UP, 3 STEP_DOWN
- req_arg  in  DATA_WIDTH  LOAD value, or step count k in low STEP_WIDTH bits
- ctrl  out  3  register ctrl code: 0 NONE, 1 CLR, 2 LOAD, 3 INCR, 4 DECR
- data_out  out  DATA_WIDTH  drives register data_input; valid while ctrl = LOAD
- busy  out  1  high from acceptance until the cycle after done
- done  out  1  one-cycle completion pulse
- shadow  out  DATA_WIDTH  expected value of the driven register

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: req_ready=1, ctrl=NONE, busy=0. On req_valid && req_ready at an edge: latch op, arg; load step counter; go ISSUE (or DONE directly if op is STEP_* with k=0).
- ISSUE: ctrl driven from latched op each cycle:
  - CLEAR: ctrl=CLR for 1 cycle; shadow <= 0.
  - LOAD: ctrl=LOAD, data_out=latched arg for 1 cycle; shadow <= arg.
  - STEP_UP: ctrl=INCR for exactly k cycles; shadow <= shadow+1 each cycle.
  - STEP_DOWN: ctrl=DECR for exactly k cycles; shadow <= shadow-1 each cycle.
  - After last issue cycle go DONE.
- DONE: ctrl=NONE, done=1, req_ready=0, busy=1 for one cycle; then IDLE.
- Shadow arithmetic modulo 2^DATA_WIDTH, identical to register wrap (0xFF+1 -> 0x00, 0x00-1 -> 0xFF for width 8).
- req_op/req_arg changes while not in IDLE are ignored; req_arg bits above STEP_WIDTH ignored for STEP_*.
- data_out = 0 whenever ctrl != LOAD.
- No back-to-back acceptance: minimum spacing between accepts is (issue cycles + 2).

## Timing
- Reset (rst=0, asynchronous): state IDLE, ctrl=NONE, data_out=0, done=0, busy=0, shadow=0, step counter=0; req_ready=1 once in IDLE. Reset mid-ISSUE aborts immediately: ctrl=NONE in the same cycle rst falls, no done pulse.
- Register shares the same rst, so shadow and register both read 0 after reset.
- Accept at edge E0 -> first issue cycle E0..E1 (ctrl valid, register samples at E1).
- CLEAR/LOAD: done high E1..E2, req_ready high again from E2. Latency accept-to-done = 1 cycle.
- STEP k>=1: ctrl active E0..Ek, done Ek..Ek+1, ready from Ek+1.
- STEP k=0: no ctrl activity; done E0..E1, ready from E1.
- shadow updates on the same edge the register updates, so shadow == register output every cycle.
- ctrl, data_out, done, busy, req_ready are functions of registered state only (Moore); no combinational path from req_* to ctrl.

## Test plan
- Reset then idle: assert rst=0 mid-cycle -> ctrl=0, shadow=0, done=0, busy=0, req_ready=1 immediately; held idle 10 cycles -> ctrl stays 0.
- LOAD 0xA5 then STEP_UP k=3 (DATA_WIDTH=8) -> ctrl=2 with data_out=0xA5 for 1 cycle, done, then ctrl=3 for exactly 3 cycles, done; shadow and attached register both 0xA8.
- Wrap: LOAD 0xFE, STEP_UP k=4 -> shadow 0x02; STEP_DOWN k=5 -> shadow 0xFD; register matches every cycle.
- STEP_DOWN k=0 and arg=0x30 (low 4 bits zero) -> no non-zero ctrl, done one cycle after accept, shadow unchanged.
- Handshake: req_valid held high with changing req_op during STEP_UP k=15 -> req_ready=0 for 16 cycles, only first request executed, next accepted exactly the cycle after done falls.
- Reset mid-operation: pull rst low on 2nd cycle of STEP_UP k=8 -> ctrl=0 asynchronously, no done pulse, shadow=0, register=0; after rst release, CLEAR request completes normally in 2 cycles.
